// File: rtl/unified_mem_ctrl_pkg.sv
// Shared definitions for the unified instruction/data byte-memory controller:
// funct3 size codes, FSM encoding and the latched access payload.
package unified_mem_ctrl_pkg;

    localparam int unsigned ADDR_W_DEF = 12;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [2:0]  size;
        logic [31:0] wdata;
    } access_t;

    // Index of the final byte of an access; unknown codes behave as a word.
    function automatic logic [1:0] last_byte_idx(input logic [2:0] size);
        case (size)
            F3_B, F3_BU: return 2'd0;
            F3_H, F3_HU: return 2'd1;
            default:     return 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/unified_mem_ctrl_load_ext.sv
// Sign/zero extension of assembled little-endian load lanes by funct3 size.
module unified_mem_ctrl_load_ext
    import unified_mem_ctrl_pkg::*;
(
    input  logic [31:0] raw,
    input  logic [2:0]  size,
    output logic [31:0] ext
);

    always_comb begin
        ext = raw;
        case (size)
            F3_B:    ext = {{24{raw[7]}}, raw[7:0]};
            F3_H:    ext = {{16{raw[15]}}, raw[15:0]};
            F3_BU:   ext = {24'h000000, raw[7:0]};
            F3_HU:   ext = {16'h0000, raw[15:0]};
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/unified_mem_ctrl.sv
// Shares one byte-wide asynchronous-read memory between instruction fetch and
// load/store, round-robin arbitrated, one byte per cycle.
module unified_mem_ctrl
    import unified_mem_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ready,
    output logic [31:0]       if_inst,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_size,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_ready,
    output logic [31:0]       dm_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    output logic              busy
);

    state_t            state_q, state_d;
    logic              grant, grant_data, contest;
    logic              last_data_q, sel_data_q;
    access_t           acc_q;
    logic [ADDR_W-1:0] base_q;
    logic [1:0]        cnt_q, last_idx_q;
    logic [31:0]       lanes_q, lanes_d, ext;
    logic              last_byte;

    assign last_byte = (cnt_q == last_idx_q);

    // Next state and grant; the round-robin bit only moves when both contend.
    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        grant_data = 1'b0;
        contest    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (if_req || dm_req) begin
                    grant      = 1'b1;
                    contest    = if_req && dm_req;
                    grant_data = contest ? !last_data_q : dm_req;
                    state_d    = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (last_byte) state_d = ST_RESP;
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Current read byte merged into its lane so the final byte is usable at once.
    always_comb begin
        lanes_d = lanes_q;
        lanes_d[{cnt_q, 3'b000} +: 8] = mem_rdata;
    end

    unified_mem_ctrl_load_ext u_load_ext (
        .raw  (lanes_d),
        .size (acc_q.size),
        .ext  (ext)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            last_data_q <= 1'b1;
            sel_data_q  <= 1'b0;
            acc_q       <= '0;
            base_q      <= '0;
            cnt_q       <= '0;
            last_idx_q  <= '0;
            lanes_q     <= '0;
            if_inst     <= '0;
            dm_rdata    <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                sel_data_q  <= grant_data;
                if (contest) last_data_q <= grant_data;
                base_q      <= grant_data ? dm_addr : if_addr;
                acc_q.we    <= grant_data && dm_we;
                acc_q.size  <= grant_data ? dm_size : F3_W;
                acc_q.wdata <= grant_data ? dm_wdata : 32'h0;
                last_idx_q  <= grant_data ? last_byte_idx(dm_size) : 2'd3;
                cnt_q       <= '0;
                lanes_q     <= '0;
            end else if (state_q == ST_ACCESS) begin
                cnt_q <= cnt_q + 2'd1;
                if (!acc_q.we) lanes_q <= lanes_d;
                if (last_byte && !acc_q.we) begin
                    if (sel_data_q) dm_rdata <= ext;
                    else            if_inst  <= ext;
                end
            end
        end
    end

    // Memory-side and handshake outputs decode registered state only.
    assign busy      = (state_q != ST_IDLE);
    assign if_ready  = (state_q == ST_RESP) && !sel_data_q;
    assign dm_ready  = (state_q == ST_RESP) && sel_data_q;
    assign mem_addr  = (state_q == ST_ACCESS) ? base_q + ADDR_W'(cnt_q) : '0;
    assign mem_we    = (state_q == ST_ACCESS) && acc_q.we;
    assign mem_wdata = mem_we ? acc_q.wdata[{cnt_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_unified_mem_ctrl.sv
// Directed and randomized bench for unified_mem_ctrl against a
// transaction-level model of the shared memory.
module tb_unified_mem_ctrl;

    localparam int unsigned AW    = 12;
    localparam int unsigned DEPTH = 4096;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0;
    logic [AW-1:0] if_addr = '0;
    logic          if_ready;
    logic [31:0]   if_inst;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [2:0]    dm_size = 3'b000;
    logic [AW-1:0] dm_addr = '0;
    logic [31:0]   dm_wdata = '0;
    logic          dm_ready;
    logic [31:0]   dm_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic          busy;

    logic [7:0] mem     [DEPTH];
    logic [7:0] ref_mem [DEPTH];

    int errors = 0;
    int checks = 0;

    unified_mem_ctrl #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_inst(if_inst),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] = mem_wdata;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int nbytes(input logic [2:0] sz);
        case (sz)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    // Little-endian value of n bytes from the reference image, signed for B/H.
    function automatic logic [31:0] model_value(input logic [11:0] a, input logic [2:0] sz, input int n);
        longint v;
        longint half;
        v = 0;
        for (int i = 0; i < n; i++) v += longint'(ref_mem[12'(int'(a) + i)]) << (8 * i);
        half = longint'(1) << (8 * n - 1);
        if ((sz == 3'b000 || sz == 3'b001) && v >= half) v -= 2 * half;
        return 32'(v);
    endfunction

    task automatic do_op(input string name, input bit fetch, input bit we, input logic [2:0] sz,
                         input logic [11:0] a, input logic [31:0] wd, input int exp_lat,
                         input logic [31:0] exp_val);
        int c;
        bit seen;
        @(negedge clk);
        if (fetch) begin
            if_req = 1'b1; if_addr = a;
        end else begin
            dm_req = 1'b1; dm_we = we; dm_size = sz; dm_addr = a; dm_wdata = wd;
        end
        c = 0;
        seen = 1'b0;
        while (!seen && c < 20) begin
            @(negedge clk);
            c++;
            if (fetch ? if_ready : dm_ready) seen = 1'b1;
        end
        check({name, " latency"}, 32'(c), 32'(exp_lat));
        if (!we) check({name, " data"}, fetch ? if_inst : dm_rdata, exp_val);
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    task automatic contest(input string name, input int exp_if_c, input int exp_dm_c);
        int c, if_c, dm_c;
        @(negedge clk);
        if_req = 1'b1; if_addr = 12'h010;
        dm_req = 1'b1; dm_we = 1'b0; dm_size = 3'b000; dm_addr = 12'h020;
        c = 0; if_c = -1; dm_c = -1;
        while ((if_c < 0 || dm_c < 0) && c < 30) begin
            @(negedge clk);
            c++;
            if (if_ready) begin if_c = c; if_req = 1'b0; end
            if (dm_ready) begin dm_c = c; dm_req = 1'b0; end
        end
        check({name, " fetch ready cycle"}, 32'(if_c), 32'(exp_if_c));
        check({name, " data ready cycle"}, 32'(dm_c), 32'(exp_dm_c));
        if_req = 1'b0;
        dm_req = 1'b0;
    endtask

    initial begin
        int cyc, k, grant_c, ready_c, free_c, cur_n, dm_pulses, diff;
        bit cur_data, cur_we, m_last_data, if_drop, dm_drop, draining;
        logic [11:0] cur_base, exp_addr;
        logic [31:0] cur_wd, cur_val, exp_if_inst, exp_dm_rdata;
        logic [7:0]  exp_wd;

        for (int i = 0; i < int'(DEPTH); i++) mem[i] = 8'($urandom);
        mem[12'h010] = 8'h13; mem[12'h011] = 8'h05; mem[12'h012] = 8'h10; mem[12'h013] = 8'h00;
        mem[12'h020] = 8'h80;
        mem[12'h040] = 8'h00; mem[12'h041] = 8'h00; mem[12'h042] = 8'h5A;
        mem[12'hFFE] = 8'h11; mem[12'hFFF] = 8'h22; mem[12'h000] = 8'h33; mem[12'h001] = 8'h44;
        for (int i = 'h80; i < 'h84; i++) mem[i] = 8'h00;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset if_ready", 32'(if_ready), 0);
        check("reset dm_ready", 32'(dm_ready), 0);
        check("reset if_inst", if_inst, 0);
        check("reset dm_rdata", dm_rdata, 0);
        check("reset mem_we", 32'(mem_we), 0);
        check("reset mem_addr", 32'(mem_addr), 0);
        check("reset busy", 32'(busy), 0);

        contest("contest1", 5, 8);
        contest("contest2", 8, 2);

        do_op("fetch 010", 1'b1, 1'b0, 3'b010, 12'h010, 0, 5, 32'h00100513);
        do_op("lb 020", 1'b0, 1'b0, 3'b000, 12'h020, 0, 2, 32'hFFFFFF80);
        do_op("lbu 020", 1'b0, 1'b0, 3'b100, 12'h020, 0, 2, 32'h00000080);
        do_op("sh 040", 1'b0, 1'b1, 3'b001, 12'h040, 32'hABCD1234, 3, 0);
        check("sh byte 040", 32'(mem[12'h040]), 32'h34);
        check("sh byte 041", 32'(mem[12'h041]), 32'h12);
        check("sh byte 042", 32'(mem[12'h042]), 32'h5A);
        do_op("lw ffe wrap", 1'b0, 1'b0, 3'b010, 12'hFFE, 0, 5, 32'h44332211);

        // Reset in the second byte cycle of a store.
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b1; dm_size = 3'b010; dm_addr = 12'h080; dm_wdata = 32'hDDCCBBAA;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("sw byte1 addr", 32'(mem_addr), 32'h081);
        check("sw byte1 we", 32'(mem_we), 1);
        rst = 1'b1;
        #1;
        check("rst mid sw mem_we", 32'(mem_we), 0);
        check("rst mid sw busy", 32'(busy), 0);
        check("rst mid sw mem_addr", 32'(mem_addr), 0);
        check("rst mid sw mem_wdata", 32'(mem_wdata), 0);
        check("rst mid sw if_inst", if_inst, 0);
        check("rst mid sw dm_rdata", dm_rdata, 0);
        @(negedge clk);
        dm_req = 1'b0;
        rst = 1'b0;
        dm_pulses = 0;
        repeat (6) begin
            @(negedge clk);
            if (dm_ready) dm_pulses++;
        end
        check("rst mid sw no ready", 32'(dm_pulses), 0);
        check("rst mid sw byte 080", 32'(mem[12'h080]), 32'hAA);
        check("rst mid sw byte 081", 32'(mem[12'h081]), 32'h00);

        // Randomized phase from a fresh reset.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = mem[i];
        check("model fetch 010", model_value(12'h010, 3'b010, 4), 32'h00100513);
        check("model lb 020", model_value(12'h020, 3'b000, 1), 32'hFFFFFF80);
        check("model lw ffe", model_value(12'hFFE, 3'b010, 4), 32'h44332211);

        cyc = 0; grant_c = -100; ready_c = -100; free_c = 0; cur_n = 0;
        cur_data = 1'b0; cur_we = 1'b0; m_last_data = 1'b1;
        if_drop = 1'b0; dm_drop = 1'b0; draining = 1'b0;
        cur_base = '0; cur_wd = '0; cur_val = '0;
        exp_if_inst = '0; exp_dm_rdata = '0;

        while (cyc < 3040) begin
            @(negedge clk);
            cyc++;
            if (cyc >= 3000) draining = 1'b1;

            k = cyc - grant_c;
            if (cyc == ready_c && !cur_we) begin
                if (cur_data) exp_dm_rdata = cur_val;
                else          exp_if_inst  = cur_val;
            end
            check("busy", 32'(busy), 32'(cyc > grant_c && cyc <= ready_c));
            check("if_ready", 32'(if_ready), 32'(cyc == ready_c && !cur_data));
            check("dm_ready", 32'(dm_ready), 32'(cyc == ready_c && cur_data));
            check("if_inst", if_inst, exp_if_inst);
            check("dm_rdata", dm_rdata, exp_dm_rdata);
            if (k >= 1 && k <= cur_n) begin
                exp_addr = cur_base + 12'(k - 1);
                exp_wd   = cur_we ? cur_wd[8*(k-1) +: 8] : 8'h00;
                check("mem_addr", 32'(mem_addr), 32'(exp_addr));
                check("mem_we", 32'(mem_we), 32'(cur_we));
                check("mem_wdata", 32'(mem_wdata), 32'(exp_wd));
            end else begin
                check("idle mem_we", 32'(mem_we), 0);
                check("idle mem_addr", 32'(mem_addr), 0);
            end

            if (if_req && if_ready) begin if_req = 1'b0; if_drop = 1'b1; end
            else if_drop = 1'b0;
            if (dm_req && dm_ready) begin dm_req = 1'b0; dm_drop = 1'b1; end
            else dm_drop = 1'b0;
            if (!draining) begin
                if (!if_req && !if_drop && $urandom_range(0, 3) == 0) begin
                    if_req = 1'b1; if_addr = 12'($urandom);
                end
                if (!dm_req && !dm_drop && $urandom_range(0, 2) == 0) begin
                    dm_req = 1'b1; dm_we = 1'($urandom_range(0, 1)); dm_size = 3'($urandom_range(0, 7));
                    dm_addr = 12'($urandom); dm_wdata = $urandom;
                end
            end

            if (cyc >= free_c && (if_req || dm_req)) begin
                if (if_req && dm_req) begin
                    cur_data = !m_last_data;
                    m_last_data = cur_data;
                end else begin
                    cur_data = dm_req;
                end
                cur_we   = cur_data && dm_we;
                cur_base = cur_data ? dm_addr : if_addr;
                cur_n    = cur_data ? nbytes(dm_size) : 4;
                cur_wd   = dm_wdata;
                if (cur_we) begin
                    for (int i = 0; i < cur_n; i++) ref_mem[12'(int'(cur_base) + i)] = cur_wd[8*i +: 8];
                    cur_val = '0;
                end else begin
                    cur_val = model_value(cur_base, cur_data ? dm_size : 3'b010, cur_n);
                end
                grant_c = cyc;
                ready_c = cyc + cur_n + 1;
                free_c  = cyc + cur_n + 2;
            end
        end

        diff = 0;
        for (int i = 0; i < int'(DEPTH); i++) if (mem[i] !== ref_mem[i]) diff++;
        check("memory image bytes differing", 32'(diff), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/unified_mem_ctrl.md
# unified_mem_ctrl

Controller that shares one byte-wide, single-ported, asynchronous-read memory between the instruction-fetch path and the load/store path of the RV32I core. It accepts word fetches and sized loads and stores, arbitrates between them round-robin, and sequences each access as serial byte cycles. It assembles little-endian results, with sign or zero extension for loads. It sits between the fetch/execute stages and the shared 4096-byte memory array.

## Interface
- ADDR_W, 12, byte-address width; memory depth 2^ADDR_W bytes.
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request; level, held until if_ready.
- if_addr  in  ADDR_W  fetch byte address.
- if_ready  out  1  one-cycle pulse; if_inst valid this cycle.
- if_inst  out  32  fetched word; holds until the next fetch completes.
- dm_req  in  1  data request; level, held until dm_ready.
- dm_we  in  1  1 = store, 0 = load.
- dm_size  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU; any other code is treated as W.
- dm_addr  in  ADDR_W  data byte address.
- dm_wdata  in  32  store data, low bytes used.
- dm_ready  out  1  one-cycle pulse; dm_rdata valid on loads, store complete.
- dm_rdata  out  32  extended load result; holds until the next load completes.
- mem_addr  out  ADDR_W  byte address to memory.
- mem_we  out  1  byte write enable.
- mem_wdata  out  8  byte to write.
- mem_rdata  in  8  combinational read byte at mem_addr.
- busy  out  1  high when not IDLE.

## Operation
- States:
  - IDLE → ACCESS on grant.
  - ACCESS → RESP after the N-th byte.
  - RESP → IDLE.
- Byte count N per access: fetch 4; B/BU 1; H/HU 2; W 4.
- Grant, sampled in IDLE only:
  - If only one request is pending, that requester is granted.
  - If both are pending, the requester not granted last time wins.
  - last_grant resets to "data", so the first contest goes to fetch.
- At grant, latch base address, N, we, size and wdata. Clear byte counter cnt.
- ACCESS drives these signals:
  - mem_addr = base + cnt, mod 2^ADDR_W. Accesses wrap around and may be misaligned; no exception is raised.
  - Loads and fetches: mem_rdata is captured into byte lane cnt at each rising edge.
  - Stores: mem_we = 1 and mem_wdata = wdata[8*cnt+7 : 8*cnt].
- RESP:
  - Pulse the ready output of the granted requester.
  - Drive the assembled word to if_inst (fetch) or dm_rdata (load). Lanes above N are filled by sign extension (B/H) or zeros (BU/HU/W/fetch).
  - Stores leave dm_rdata unchanged.
- Requests are not sampled in RESP. The requester drops req in the RESP cycle.
- A req that is still high in IDLE is treated as a new request.
- Reset values: state IDLE, all outputs 0, last_grant = data.
- Reset asserted mid-access:
  - Return to IDLE immediately.
  - mem_we drops immediately; it is decoded from registered state.
  - No ready pulse is issued.
  - Bytes already written stay written.
- mem_we, mem_addr and mem_wdata are 0 outside ACCESS.

## Timing
- Cycle 0: req high in IDLE; grant at the rising edge ending cycle 0.
- Cycles 1..N: byte accesses, one byte per cycle.
- Cycle N+1: ready pulse (RESP).
- Cycle N+2: IDLE; the earliest next grant is at the edge ending cycle N+2.
- Latencies from request to ready: fetch 5 cycles, LB 2, LH 3, LW/SW 5.
- Back-to-back throughput: one access per N+2 cycles.
- All outputs are registered or decoded only from registered state. There is no combinational path from req inputs to outputs.

## Structure
- Put the funct3 size constants and the state encoding in the shared defines file.
- Sub-module load_ext: combinational. Inputs are the 32-bit raw lanes and the size code; output is the extended word. It is unit-testable on its own.
- The top contains the FSM, counter, round-robin bit and byte-lane capture.

## Test plan
- Fetch at 0x010, with memory bytes 13 05 10 00 at 0x010..0x013 → if_ready pulses in cycle 5 and if_inst = 0x00100513.
- LB at 0x020 where the byte is 0x80 → dm_ready in cycle 2 with dm_rdata = 0xFFFFFF80. LBU at the same address → 0x00000080.
- SH with dm_wdata = 0xABCD1234 at 0x040 → 0x34 written to 0x040 and 0x12 to 0x041. 0x042 is untouched and dm_ready pulses in cycle 3.
- Both requests high after reset → fetch is served first, then data. The next simultaneous pair is served data first, then fetch.
- LW at 0xFFE with ADDR_W = 12 → bytes read from 0xFFE, 0xFFF, 0x000, 0x001, assembled little-endian.
- rst asserted during the 2nd byte cycle of an SW → mem_we low in the same cycle and only address base+0 is written. No dm_ready pulse, all outputs 0, state IDLE.
